// File: rtl/sparse_pkg.sv
// Shared definitions for the sparse CIM datapath: FSM state encoding and
// default geometry used by the expander, MAC array and index generator.
package sparse_pkg;

    localparam int unsigned DEF_MAC_COUNT   = 256;
    localparam int unsigned DEF_DATA_WIDTH  = 8;
    localparam int unsigned DEF_INDEX_WIDTH = $clog2(DEF_MAC_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StDrain
    } state_e;

endpackage

// File: rtl/sparse_expand_buffer.sv
// Dense scatter buffer: value register file plus an occupancy bitmap.
// The bitmap is cleared in one cycle, so stale values never need a sweep;
// unoccupied positions read back as zero.
module sparse_expand_buffer
    import sparse_pkg::*;
#(
    parameter int unsigned MAC_COUNT   = DEF_MAC_COUNT,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   wr_en,
    input  logic [INDEX_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic [INDEX_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0]  rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [MAC_COUNT];
    logic [MAC_COUNT-1:0]  bitmap_q;

    // Value storage needs no reset: the bitmap masks anything stale.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Occupancy tracking with single-cycle clear-all.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bitmap_q <= '0;
        end else if (wr_en) begin
            bitmap_q[wr_addr] <= 1'b1;
        end
    end

    // Read port returns zero for positions not written this frame.
    always_comb begin
        rd_data = bitmap_q[rd_addr] ? mem_q[rd_addr] : '0;
    end

endmodule

// File: rtl/sparse_csr_expander.sv
// CSR sparse-to-dense expander: takes a header with the non-zero count, then
// strictly increasing (index, value) pairs, and streams the dense vector out
// one element per cycle with zeros at skipped positions.
module sparse_csr_expander
    import sparse_pkg::*;
#(
    parameter int unsigned MAC_COUNT   = DEF_MAC_COUNT,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hdr_valid,
    output logic                   hdr_ready,
    input  logic [INDEX_WIDTH:0]   hdr_count,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INDEX_WIDTH-1:0] in_index,
    input  logic [DATA_WIDTH-1:0]  in_value,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [INDEX_WIDTH-1:0] out_index,
    output logic                   out_last,
    output logic                   busy,
    output logic                   frame_done,
    output logic [INDEX_WIDTH:0]   nnz_count,
    output logic                   err
);

    localparam logic [INDEX_WIDTH:0]   MaxCount = (INDEX_WIDTH + 1)'(MAC_COUNT);
    localparam logic [INDEX_WIDTH:0]   CntOne   = (INDEX_WIDTH + 1)'(1);
    localparam logic [INDEX_WIDTH-1:0] PtrOne   = INDEX_WIDTH'(1);
    localparam logic [INDEX_WIDTH-1:0] LastPtr  = INDEX_WIDTH'(MAC_COUNT - 1);

    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] rd_ptr_q;
    logic [INDEX_WIDTH-1:0] last_idx_q;
    logic [INDEX_WIDTH:0]   target_q;
    logic [INDEX_WIDTH:0]   received_q;
    logic [INDEX_WIDTH:0]   nnz_q;
    logic                   err_q;
    logic                   frame_done_q;

    logic                   hdr_fire;
    logic                   wr_en;
    logic [INDEX_WIDTH:0]   target_d;
    logic [DATA_WIDTH-1:0]  rd_data;

    // Handshake decode and order check; readies depend on state only.
    always_comb begin
        hdr_ready = (state_q == StIdle);
        in_ready  = (state_q == StFill);
        out_valid = (state_q == StDrain);
        busy      = (state_q != StIdle);
        hdr_fire  = hdr_ready && hdr_valid;
        target_d  = (hdr_count > MaxCount) ? MaxCount : hdr_count;
        // First entry of a frame may land anywhere; later ones must climb.
        wr_en     = in_ready && in_valid && ((nnz_q == '0) || (in_index > last_idx_q));
        out_data  = out_valid ? rd_data : '0;
        out_index = rd_ptr_q;
        out_last  = out_valid && (rd_ptr_q == LastPtr);
    end

    assign frame_done = frame_done_q;
    assign nnz_count  = nnz_q;
    assign err        = err_q;

    // Frame FSM with counters, error flag and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            rd_ptr_q     <= '0;
            last_idx_q   <= '0;
            target_q     <= '0;
            received_q   <= '0;
            nnz_q        <= '0;
            err_q        <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (hdr_fire) begin
                        rd_ptr_q   <= '0;
                        received_q <= '0;
                        nnz_q      <= '0;
                        err_q      <= (hdr_count > MaxCount);
                        target_q   <= target_d;
                        state_q    <= (target_d == '0) ? StDrain : StFill;
                    end
                end
                StFill: begin
                    if (in_valid) begin
                        received_q <= received_q + CntOne;
                        if (wr_en) begin
                            nnz_q      <= nnz_q + CntOne;
                            last_idx_q <= in_index;
                        end else begin
                            // Dropped entries still count toward the target.
                            err_q <= 1'b1;
                        end
                        if ((received_q + CntOne) == target_q) begin
                            state_q <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        rd_ptr_q <= rd_ptr_q + PtrOne;
                        if (rd_ptr_q == LastPtr) begin
                            state_q      <= StIdle;
                            frame_done_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    sparse_expand_buffer #(
        .MAC_COUNT  (MAC_COUNT),
        .DATA_WIDTH (DATA_WIDTH),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_buffer (
        .clk    (clk),
        .rst    (rst),
        .clear  (hdr_fire),
        .wr_en  (wr_en),
        .wr_addr(in_index),
        .wr_data(in_value),
        .rd_addr(rd_ptr_q),
        .rd_data(rd_data)
    );

endmodule

// File: tb/tb_sparse_csr_expander.sv
// Directed bench for sparse_csr_expander: table of small frames plus
// hand-written clamp, backpressure and mid-frame reset sequences.
module tb_sparse_csr_expander;

    localparam int MC = 256;

    logic       clk = 1'b0;
    logic       rst;
    logic       hdr_valid;
    logic       hdr_ready;
    logic [8:0] hdr_count;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_index;
    logic [7:0] in_value;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [7:0] out_index;
    logic       out_last;
    logic       busy;
    logic       frame_done;
    logic [8:0] nnz_count;
    logic       err;

    int errors = 0;
    int checks = 0;

    logic [7:0] ent_idx   [MC];
    logic [7:0] ent_val   [MC];
    logic [7:0] exp_dense [MC];

    typedef struct packed {
        logic [8:0]      hdr;
        logic [2:0]      n;
        logic [2:0][7:0] idx;
        logic [2:0][7:0] val;
        logic [2:0]      ne;
        logic [2:0][7:0] eidx;
        logic [2:0][7:0] evl;
        logic [8:0]      nnz;
        logic            err;
    } vec_t;

    vec_t vecs [5];

    sparse_csr_expander dut (
        .clk       (clk),
        .rst       (rst),
        .hdr_valid (hdr_valid),
        .hdr_ready (hdr_ready),
        .hdr_count (hdr_count),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_value  (in_value),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last),
        .busy      (busy),
        .frame_done(frame_done),
        .nnz_count (nnz_count),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input bit ok, input string nm, input int act, input int expv);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    function automatic vec_t mk(input int hdr, input int n,
                                input int i0, input int v0, input int i1, input int v1,
                                input int i2, input int v2, input int ne,
                                input int e0, input int w0, input int e1, input int w1,
                                input int e2, input int w2, input int nnz, input bit er);
        vec_t v;
        v.hdr = 9'(hdr);   v.n = 3'(n);
        v.idx[0] = 8'(i0); v.val[0] = 8'(v0);
        v.idx[1] = 8'(i1); v.val[1] = 8'(v1);
        v.idx[2] = 8'(i2); v.val[2] = 8'(v2);
        v.ne = 3'(ne);
        v.eidx[0] = 8'(e0); v.evl[0] = 8'(w0);
        v.eidx[1] = 8'(e1); v.evl[1] = 8'(w1);
        v.eidx[2] = 8'(e2); v.evl[2] = 8'(w2);
        v.nnz = 9'(nnz);   v.err = er;
        return v;
    endfunction

    task automatic load(input vec_t v);
        for (int i = 0; i < MC; i++) exp_dense[i] = 8'h00;
        for (int k = 0; k < int'(v.n); k++) begin
            ent_idx[k] = v.idx[k];
            ent_val[k] = v.val[k];
        end
        for (int k = 0; k < int'(v.ne); k++) exp_dense[v.eidx[k]] = v.evl[k];
    endtask

    task automatic check_reset_outputs(input string nm);
        chk(hdr_ready === 1'b1, {nm, " hdr_ready"}, int'(hdr_ready), 1);
        chk(in_ready === 1'b0, {nm, " in_ready"}, int'(in_ready), 0);
        chk(out_valid === 1'b0, {nm, " out_valid"}, int'(out_valid), 0);
        chk(out_data === 8'h00, {nm, " out_data"}, int'(out_data), 0);
        chk(out_index === 8'h00, {nm, " out_index"}, int'(out_index), 0);
        chk(out_last === 1'b0, {nm, " out_last"}, int'(out_last), 0);
        chk(busy === 1'b0, {nm, " busy"}, int'(busy), 0);
        chk(frame_done === 1'b0, {nm, " frame_done"}, int'(frame_done), 0);
        chk(nnz_count === 9'd0, {nm, " nnz_count"}, int'(nnz_count), 0);
        chk(err === 1'b0, {nm, " err"}, int'(err), 0);
    endtask

    // Drives one frame (header then n entries from ent_idx/ent_val) and checks
    // the whole dense output against exp_dense. Inputs change and outputs are
    // sampled on the falling edge.
    task automatic run_frame(input int hdr, input int n, input int exp_nnz,
                             input bit exp_err, input bit bp, input string nm);
        int cyc;
        int p;
        int budget;
        bit stalled;
        logic [7:0] hd;
        logic [7:0] hi;
        logic       hl;
        @(negedge clk);
        chk(hdr_ready === 1'b1, {nm, " hdr_ready idle"}, int'(hdr_ready), 1);
        hdr_valid = 1'b1;
        hdr_count = 9'(hdr);
        out_ready = 1'b1;
        cyc = 0;
        @(negedge clk);
        cyc++;
        hdr_valid = 1'b0;
        chk(busy === 1'b1, {nm, " busy after hdr"}, int'(busy), 1);
        chk(hdr_ready === 1'b0, {nm, " hdr_ready busy"}, int'(hdr_ready), 0);
        if (n > 0) chk(in_ready === 1'b1, {nm, " in_ready T+1"}, int'(in_ready), 1);
        for (int k = 0; k < n; k++) begin
            chk(in_ready === 1'b1 && out_valid === 1'b0, {nm, " fill ready"},
                int'(in_ready), 1);
            in_valid = 1'b1;
            in_index = ent_idx[k];
            in_value = ent_val[k];
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        chk(out_valid === 1'b1, {nm, " first out_valid"}, int'(out_valid), 1);
        chk(in_ready === 1'b0, {nm, " in_ready drain"}, int'(in_ready), 0);
        p = 0;
        budget = 0;
        stalled = 1'b0;
        hd = '0; hi = '0; hl = 1'b0;
        while (p < MC && budget < 4000) begin
            if (out_valid !== 1'b1) begin
                chk(1'b0, {nm, " out_valid dropped"}, int'(out_valid), 1);
                break;
            end
            if (stalled) begin
                chk(out_data === hd && out_index === hi && out_last === hl,
                    {nm, " held while stalled"}, int'(out_index), int'(hi));
            end
            chk(out_index === 8'(p), {nm, " out_index"}, int'(out_index), p);
            chk(out_data === exp_dense[p], {nm, " out_data"},
                int'($signed(out_data)), int'($signed(exp_dense[p])));
            chk(out_last === (p == MC - 1), {nm, " out_last"}, int'(out_last),
                int'(p == MC - 1));
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            stalled = !out_ready;
            hd = out_data; hi = out_index; hl = out_last;
            if (out_ready) p++;
            @(negedge clk);
            cyc++;
            budget++;
        end
        out_ready = 1'b1;
        if (p < MC) chk(1'b0, {nm, " drain incomplete"}, p, MC);
        chk(frame_done === 1'b1, {nm, " frame_done pulse"}, int'(frame_done), 1);
        if (!bp) chk(cyc == 1 + n + MC, {nm, " frame length"}, cyc, 1 + n + MC);
        chk(busy === 1'b0 && out_valid === 1'b0, {nm, " idle after"}, int'(busy), 0);
        chk(nnz_count === 9'(exp_nnz), {nm, " nnz_count"}, int'(nnz_count), exp_nnz);
        chk(err === exp_err, {nm, " err"}, int'(err), int'(exp_err));
        @(negedge clk);
        chk(frame_done === 1'b0, {nm, " frame_done one cycle"}, int'(frame_done), 0);
        chk(nnz_count === 9'(exp_nnz) && err === exp_err, {nm, " status held"},
            int'(nnz_count), exp_nnz);
    endtask

    initial begin
        rst       = 1'b1;
        hdr_valid = 1'b0;
        hdr_count = '0;
        in_valid  = 1'b0;
        in_index  = '0;
        in_value  = '0;
        out_ready = 1'b1;

        vecs[0] = mk(3, 3, 5, 7, 17, -3, 255, 1, 3, 5, 7, 17, -3, 255, 1, 3, 1'b0);
        vecs[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        vecs[2] = mk(2, 2, 9, 4, 9, 8, 0, 0, 1, 9, 4, 0, 0, 0, 0, 1, 1'b1);
        vecs[3] = mk(3, 3, 10, 0, 3, 5, 20, -128, 2, 10, 0, 20, -128, 0, 0, 2, 1'b1);
        vecs[4] = mk(1, 1, 0, -1, 0, 0, 0, 0, 1, 0, -1, 0, 0, 0, 0, 1, 1'b0);

        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("in reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after reset");

        for (int v = 0; v < 5; v++) begin
            load(vecs[v]);
            run_frame(int'(vecs[v].hdr), int'(vecs[v].n), int'(vecs[v].nnz),
                      vecs[v].err, 1'b0, $sformatf("vec%0d", v));
        end

        // Oversized header: clamped to a full frame, flagged, all indices sent.
        for (int i = 0; i < MC; i++) begin
            ent_idx[i]   = 8'(i);
            ent_val[i]   = 8'(i * 37 + 11);
            exp_dense[i] = 8'(i * 37 + 11);
        end
        run_frame(300, MC, MC, 1'b1, 1'b0, "clamp300");

        // Same content as the first vector under random output stalls.
        load(vecs[0]);
        run_frame(3, 3, 3, 1'b0, 1'b1, "backpressure");

        // Reset in the middle of FILL after one entry.
        @(negedge clk);
        hdr_valid = 1'b1;
        hdr_count = 9'd3;
        @(negedge clk);
        hdr_valid = 1'b0;
        in_valid  = 1'b1;
        in_index  = 8'd40;
        in_value  = 8'd9;
        @(negedge clk);
        in_valid = 1'b0;
        chk(nnz_count === 9'd1, "midfill nnz before rst", int'(nnz_count), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midfill rst");
        rst = 1'b0;
        @(negedge clk);
        chk(frame_done === 1'b0 && hdr_ready === 1'b1, "post rst no done",
            int'(frame_done), 0);
        load(vecs[1]);
        run_frame(0, 0, 0, 1'b0, 1'b0, "post rst zeros");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
